// File: rtl/jpeg_enc_pkg.sv
// rtl/jpeg_enc_pkg.sv - shared geometry, pixel/block types and column clamp helper
// Contents:
//   PX_WIDTH, BLOCK_LINES, BEAT_WIDTH, COL_W : block geometry
//   px_t, block_t, idx_t                     : pixel, block and row/column index types
//   clamp_col()                              : limits a column index to the last written column
package jpeg_enc_pkg;

  localparam int PX_WIDTH    = 8;
  localparam int BLOCK_LINES = 8;
  localparam int BEAT_WIDTH  = ((PX_WIDTH * BLOCK_LINES + 7) / 8) * 8;
  localparam int COL_W       = (BLOCK_LINES > 1) ? $clog2(BLOCK_LINES) : 1;

  typedef logic [PX_WIDTH-1:0] px_t;
  // Indexed [row][column]; a row is one line of the strip.
  typedef px_t [BLOCK_LINES-1:0][BLOCK_LINES-1:0] block_t;
  typedef logic [COL_W-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(BLOCK_LINES - 1);

  // Short strips replicate their last column into the unused columns.
  function automatic idx_t clamp_col(input idx_t col, input idx_t last);
    return (col > last) ? last : col;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// rtl/axi4_stream_if.sv - AXI4-Stream bundle used on both sides of the converter
// Signals: tdata, tvalid, tready, tlast, tuser, tstrb, tkeep
// Modports: master drives everything except tready; slave drives tready only.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 64
) ();

  logic [DATA_WIDTH-1:0]   tdata;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic                    tuser;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;

  modport master (output tdata, output tvalid, output tlast, output tuser,
                  output tstrb, output tkeep, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser,
                  input tstrb, input tkeep, output tready);

endinterface

// File: rtl/par_video_to_block_converter_block_bank.sv
// rtl/par_video_to_block_converter_block_bank.sv - one block buffer: column write, clamped row read
// Ports:
//   clk_i, rst_n_i  : clock, asynchronous active-low reset (clears flags only)
//   wr_en_i         : write wr_data_i as column wr_col_i (lane i -> row i)
//   wr_sof_i        : start-of-frame flag, captured when column 0 is written
//   close_i         : block complete; marks full and records wr_col_i as last column
//   free_i          : block fully read; clears full
//   rd_row_i        : row presented on rd_data_o (lane c -> column min(c, last column))
//   full_o, sof_o   : bank holds a complete block / block starts a frame
module block_bank
  import jpeg_enc_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  idx_t                  wr_col_i,
  input  logic [BEAT_WIDTH-1:0] wr_data_i,
  input  logic                  wr_sof_i,
  input  logic                  close_i,
  input  logic                  free_i,
  input  idx_t                  rd_row_i,
  output logic [BEAT_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  sof_o
);

  block_t mem_q;
  logic   full_q, full_d;
  logic   sof_q, sof_d;
  idx_t   last_col_q, last_col_d;

  // Pixel storage needs no reset: nothing is read until full_q is set.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int i = 0; i < BLOCK_LINES; i++) begin
        mem_q[i][wr_col_i] <= wr_data_i[i*PX_WIDTH +: PX_WIDTH];
      end
    end
  end

  // close and free never hit the same bank in one cycle: the writer is
  // blocked from a full bank, and only a full bank can be freed.
  always_comb begin
    full_d     = full_q;
    sof_d      = sof_q;
    last_col_d = last_col_q;
    if (wr_en_i && (wr_col_i == '0)) begin
      sof_d = wr_sof_i;
    end
    if (close_i) begin
      full_d     = 1'b1;
      last_col_d = wr_col_i;
    end else if (free_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      full_q     <= 1'b0;
      sof_q      <= 1'b0;
      last_col_q <= '0;
    end else begin
      full_q     <= full_d;
      sof_q      <= sof_d;
      last_col_q <= last_col_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int c = 0; c < BLOCK_LINES; c++) begin
      rd_data_o[c*PX_WIDTH +: PX_WIDTH] = mem_q[rd_row_i][clamp_col(idx_t'(c), last_col_q)];
    end
  end

  assign full_o = full_q;
  assign sof_o  = sof_q;

endmodule

// File: rtl/par_video_to_block_converter.sv
// rtl/par_video_to_block_converter.sv - collects strip columns into blocks and emits them row by row
// Ports:
//   clk_i    : single clock, rising edge
//   rst_n_i  : asynchronous active-low reset
//   video_i  : input columns (lane i = line i), tlast = end of strip, tuser = start of frame
//   block_o  : output block rows (lane c = column c), tlast = last row, tuser = first block of frame
module par_video_to_block_converter
  import jpeg_enc_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_n_i,
  axi4_stream_if.slave  video_i,
  axi4_stream_if.master block_o
);

  logic ready_en_q;
  logic wr_sel_q, wr_sel_d;
  logic rd_sel_q, rd_sel_d;
  idx_t col_cnt_q, col_cnt_d;
  idx_t row_cnt_q, row_cnt_d;

  logic [1:0]            full;
  logic [1:0]            sof;
  logic [BEAT_WIDTH-1:0] rd_data [2];

  logic wr_hs;
  logic wr_close;
  idx_t wr_col;
  logic rd_hs;
  logic rd_last;

  logic unused_strb_keep;
  assign unused_strb_keep = ^{video_i.tstrb, video_i.tkeep};

  assign video_i.tready = ready_en_q & ~full[wr_sel_q];
  assign wr_hs          = video_i.tvalid & video_i.tready;

  // A start-of-frame beat always lands in column 0; when it arrives mid-block
  // it simply overwrites the partial block in the same bank.
  assign wr_col   = video_i.tuser ? '0 : col_cnt_q;
  assign wr_close = wr_hs & ((wr_col == LAST_IDX) | video_i.tlast);

  assign rd_last = (row_cnt_q == LAST_IDX);
  assign rd_hs   = block_o.tvalid & block_o.tready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    block_bank u_bank (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .wr_en_i   (wr_hs & (wr_sel_q == 1'(b))),
      .wr_col_i  (wr_col),
      .wr_data_i (video_i.tdata),
      .wr_sof_i  (video_i.tuser),
      .close_i   (wr_close & (wr_sel_q == 1'(b))),
      .free_i    (rd_hs & rd_last & (rd_sel_q == 1'(b))),
      .rd_row_i  (row_cnt_q),
      .rd_data_o (rd_data[b]),
      .full_o    (full[b]),
      .sof_o     (sof[b])
    );
  end

  always_comb begin
    col_cnt_d = col_cnt_q;
    wr_sel_d  = wr_sel_q;
    if (wr_close) begin
      col_cnt_d = '0;
      wr_sel_d  = ~wr_sel_q;
    end else if (wr_hs) begin
      col_cnt_d = wr_col + idx_t'(1);
    end
  end

  always_comb begin
    row_cnt_d = row_cnt_q;
    rd_sel_d  = rd_sel_q;
    if (rd_hs) begin
      if (rd_last) begin
        row_cnt_d = '0;
        rd_sel_d  = ~rd_sel_q;
      end else begin
        row_cnt_d = row_cnt_q + idx_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ready_en_q <= 1'b0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
    end else begin
      ready_en_q <= 1'b1;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      col_cnt_q  <= col_cnt_d;
      row_cnt_q  <= row_cnt_d;
    end
  end

  // All outputs derive from registered state, so they hold while stalled.
  assign block_o.tvalid = full[rd_sel_q];
  assign block_o.tdata  = rd_data[rd_sel_q];
  assign block_o.tlast  = rd_last;
  assign block_o.tuser  = sof[rd_sel_q] & (row_cnt_q == '0);
  assign block_o.tstrb  = '1;
  assign block_o.tkeep  = '1;

endmodule

// File: tb/tb_par_video_to_block_converter.sv
// tb/tb_par_video_to_block_converter.sv - randomized scoreboard bench for par_video_to_block_converter
module tb_par_video_to_block_converter;
  import jpeg_enc_pkg::*;

  typedef logic [BEAT_WIDTH-1:0] beat_w;
  typedef struct {
    beat_w data;
    logic  last;
    logic  user;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_WIDTH(BEAT_WIDTH)) vin ();
  axi4_stream_if #(.DATA_WIDTH(BEAT_WIDTH)) vout ();

  par_video_to_block_converter dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .video_i (vin),
    .block_o (vout)
  );

  int checks = 0;
  int errors = 0;

  beat_t src[$];
  beat_t exp_q[$];
  beat_w part[$];
  logic  part_sof;
  logic  in_taken = 1'b0;
  int    cyc = 0;
  int    acc_cnt = 0;
  int    out_cnt = 0;
  int    in_cyc[$];
  int    out_cyc[$];
  int    out_mode = 0;   // 0: stall output, 1: always ready, 2: random ready
  bit    rand_gaps = 1'b0;

  task automatic check(input string tag, input beat_w act, input beat_w exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: a block is the list of accepted columns; output row r,
  // lane c is pixel r of column min(c, n-1).
  task automatic model_accept(input beat_w data, input logic last, input logic user);
    beat_t e;
    int    n;
    if (user && part.size() != 0) part.delete();
    if (part.size() == 0) part_sof = user;
    part.push_back(data);
    if (part.size() == BLOCK_LINES || last) begin
      n = part.size();
      for (int r = 0; r < BLOCK_LINES; r++) begin
        e.data = '0;
        for (int c = 0; c < BLOCK_LINES; c++) begin
          e.data[c*PX_WIDTH +: PX_WIDTH] = part[(c < n) ? c : n - 1][r*PX_WIDTH +: PX_WIDTH];
        end
        e.last = (r == BLOCK_LINES - 1);
        e.user = part_sof && (r == 0);
        exp_q.push_back(e);
      end
      part.delete();
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      exp_q.delete();
      part.delete();
      in_taken = 1'b0;
    end else begin
      if (vout.tvalid && vout.tready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", vout.tdata, 'x);
        end else begin
          e = exp_q.pop_front();
          check("out_data", vout.tdata, e.data);
          check("out_last", beat_w'(vout.tlast), beat_w'(e.last));
          check("out_user", beat_w'(vout.tuser), beat_w'(e.user));
        end
        out_cnt++;
        out_cyc.push_back(cyc);
      end
      in_taken = vin.tvalid && vin.tready;
      if (in_taken) begin
        model_accept(vin.tdata, vin.tlast, vin.tuser);
        acc_cnt++;
        in_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    logic hold;
    vin.tvalid  = 1'b0;
    vin.tdata   = '0;
    vin.tlast   = 1'b0;
    vin.tuser   = 1'b0;
    vin.tstrb   = '1;
    vin.tkeep   = '1;
    vout.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (in_taken && src.size() > 0) src.delete(0);
      hold = vin.tvalid && !in_taken && rst_n;
      if (src.size() > 0 && (hold || !(rand_gaps && $urandom_range(0, 3) == 0))) begin
        vin.tvalid = 1'b1;
        vin.tdata  = src[0].data;
        vin.tlast  = src[0].last;
        vin.tuser  = src[0].user;
      end else begin
        vin.tvalid = 1'b0;
        vin.tlast  = 1'b0;
        vin.tuser  = 1'b0;
      end
      vout.tready = (out_mode == 1) || (out_mode == 2 && $urandom_range(0, 2) != 0);
    end
  end

  task automatic push_col(input int col, input logic last, input logic user);
    beat_t b;
    b.data = '0;
    for (int i = 0; i < BLOCK_LINES; i++) begin
      b.data[i*PX_WIDTH +: PX_WIDTH] = px_t'(((col & 15) << 4) | (i & 15));
    end
    b.last = last;
    b.user = user;
    src.push_back(b);
  endtask

  task automatic wait_out(input int target, input int budget, input string tag);
    int n = 0;
    while (out_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(tag, beat_w'(out_cnt >= target), beat_w'(1));
    #2;
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while ((exp_q.size() > 0 || src.size() > 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #2;
    check({tag, "_exp_empty"}, beat_w'(exp_q.size()), beat_w'(0));
    check({tag, "_src_empty"}, beat_w'(src.size()), beat_w'(0));
  endtask

  initial begin
    int    base;
    beat_t b;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_tvalid", beat_w'(vout.tvalid), beat_w'(0));
    check("rst_out_tlast", beat_w'(vout.tlast), beat_w'(0));
    check("rst_out_tuser", beat_w'(vout.tuser), beat_w'(0));
    check("rst_in_tready", beat_w'(vin.tready), beat_w'(0));
    #1 rst_n = 1'b1;
    #1 check("tready_before_edge", beat_w'(vin.tready), beat_w'(0));
    @(posedge clk);
    #1 check("tready_after_edge", beat_w'(vin.tready), beat_w'(1));

    // 1: two full blocks, continuous, check pattern and 1 beat/clk
    out_mode = 1;
    @(posedge clk);
    #2;
    base = out_cnt;
    for (int c = 0; c < 16; c++) push_col(c, 1'b0, c == 0);
    wait_out(base + 16, 200, "t1_timeout");
    check("t1_in_span", beat_w'(in_cyc[15] - in_cyc[0]), beat_w'(15));
    check("t1_out_span", beat_w'(out_cyc[base + 15] - out_cyc[base]), beat_w'(15));
    check("t1_latency", beat_w'(out_cyc[base] - in_cyc[7]), beat_w'(1));
    drain(100, "t1");

    // 2: frame start flag on a fresh frame
    for (int c = 0; c < 16; c++) push_col(c + 3, 1'b0, c == 0);
    drain(200, "t2");

    // 3: output stalled for 40 cycles during continuous input
    out_mode = 0;
    @(posedge clk);
    #2;
    base = acc_cnt;
    for (int c = 0; c < 24; c++) push_col(c, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #2;
    check("t3_accepted", beat_w'(acc_cnt - base), beat_w'(16));
    check("t3_tready_low", beat_w'(vin.tready), beat_w'(0));
    out_mode = 1;
    drain(300, "t3");

    // 4: 13-column strip, second block padded with its last column
    for (int c = 0; c < 13; c++) push_col(c + 1, c == 12, c == 0);
    drain(200, "t4");

    // 5: resync at col_cnt=3
    base = out_cnt;
    for (int c = 0; c < 3; c++) push_col(c, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) push_col(c + 8, 1'b0, c == 0);
    drain(200, "t5");
    check("t5_beats", beat_w'(out_cnt - base), beat_w'(8));

    // 6: reset in the middle of a block read
    base = out_cnt;
    for (int c = 0; c < 8; c++) push_col(c, 1'b0, 1'b0);
    wait_out(base + 4, 100, "t6_timeout");
    rst_n = 1'b0;
    src.delete();
    #1 check("t6_tvalid_low", beat_w'(vout.tvalid), beat_w'(0));
    check("t6_tready_low", beat_w'(vin.tready), beat_w'(0));
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    base = out_cnt;
    repeat (12) @(posedge clk);
    #2;
    check("t6_no_stale_out", beat_w'(out_cnt - base), beat_w'(0));
    for (int c = 0; c < 8; c++) push_col(c + 5, 1'b0, c == 0);
    drain(200, "t6");
    check("t6_new_beats", beat_w'(out_cnt - base), beat_w'(8));

    // Random traffic: gaps, random backpressure, random strip ends and resyncs
    rand_gaps = 1'b1;
    out_mode  = 2;
    for (int k = 0; k < 300; k++) begin
      b.data = {$urandom, $urandom};
      b.last = (k == 299) || ($urandom_range(0, 9) == 0);
      b.user = ($urandom_range(0, 19) == 0);
      src.push_back(b);
    end
    drain(20000, "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
